// File: rtl/si5340_pkg.sv
// Shared types and constants for the Si5340 register-access sequencer.
package si5340_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PG_DEV = 4'd1,
    PG_REG = 4'd2,
    PG_VAL = 4'd3,
    W_DEV  = 4'd4,
    W_REG  = 4'd5,
    W_DATA = 4'd6,
    R_DEV  = 4'd7,
    R_DATA = 4'd8,
    ABORT  = 4'd9,
    RESP   = 4'd10
  } state_e;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h74;
  localparam logic [7:0] PAGE_REG     = 8'h01;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

endpackage

// File: rtl/si5340_reg_access.sv
// Turns single Si5340 register read/write requests into I2C byte-controller
// commands, writing the page register only when the target page changes.
//
// state  | meaning
// IDLE   | ready for a request
// PG_DEV | start + device address (write) for page select
// PG_REG | page register offset
// PG_VAL | page value + stop, updates page cache
// W_DEV  | start + device address (write)
// W_REG  | register offset
// W_DATA | write data + stop
// R_DEV  | repeated start + device address (read)
// R_DATA | read byte with master NACK + stop
// ABORT  | stop after slave NACK
// RESP   | one-cycle response pulse
module si5340_reg_access
  import si5340_pkg::state_e, si5340_pkg::req_t,
         si5340_pkg::IDLE, si5340_pkg::PG_DEV, si5340_pkg::PG_REG,
         si5340_pkg::PG_VAL, si5340_pkg::W_DEV, si5340_pkg::W_REG,
         si5340_pkg::W_DATA, si5340_pkg::R_DEV, si5340_pkg::R_DATA,
         si5340_pkg::ABORT, si5340_pkg::RESP;
#(
  parameter logic [6:0] DEV_ADDR   = si5340_pkg::DEF_DEV_ADDR,
  parameter logic [7:0] PAGE_REG   = si5340_pkg::PAGE_REG,
  parameter int         DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [15:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic                  ack_in_o,
  output logic [DATA_WIDTH-1:0] din_o,
  input  logic [DATA_WIDTH-1:0] dout_i,
  input  logic                  cmd_ack_i,
  input  logic                  rx_ack_i
);

  state_e                  state_q, state_d;
  req_t                    req_q;
  logic [7:0]              page_q;
  logic                    page_vld_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    wr_state;
  logic                    nack;
  logic                    page_hit;

  assign wr_state = state_q inside {PG_DEV, PG_REG, PG_VAL, W_DEV, W_REG, W_DATA, R_DEV};
  assign nack     = cmd_ack_i & rx_ack_i & wr_state;
  assign page_hit = page_vld_q && (req_addr_i[15:8] == page_q);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      req_q      <= '0;
      page_q     <= '0;
      page_vld_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        req_q <= '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
        err_q <= 1'b0;
      end
      if (nack) begin
        page_vld_q <= 1'b0;
        err_q      <= 1'b1;
      end else if (cmd_ack_i && state_q == PG_VAL) begin
        page_q     <= req_q.addr[15:8];
        page_vld_q <= 1'b1;
      end
      if (cmd_ack_i && state_q == R_DATA) rdata_q <= dout_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = page_hit ? W_DEV : PG_DEV;
      PG_DEV:  if (cmd_ack_i) state_d = PG_REG;
      PG_REG:  if (cmd_ack_i) state_d = PG_VAL;
      PG_VAL:  if (cmd_ack_i) state_d = W_DEV;
      W_DEV:   if (cmd_ack_i) state_d = W_REG;
      W_REG:   if (cmd_ack_i) state_d = req_q.we ? W_DATA : R_DEV;
      W_DATA:  if (cmd_ack_i) state_d = RESP;
      R_DEV:   if (cmd_ack_i) state_d = R_DATA;
      R_DATA:  if (cmd_ack_i) state_d = RESP;
      ABORT:   if (cmd_ack_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a slave NACK on any written byte overrides the normal successor
    if (nack) state_d = ABORT;
  end

  always_comb begin
    start_o  = 1'b0;
    stop_o   = 1'b0;
    read_o   = 1'b0;
    write_o  = 1'b0;
    ack_in_o = 1'b0;
    din_o    = '0;
    case (state_q)
      PG_DEV: begin start_o = 1'b1; write_o = 1'b1; din_o = {DEV_ADDR, 1'b0}; end
      PG_REG: begin write_o = 1'b1; din_o = PAGE_REG; end
      PG_VAL: begin write_o = 1'b1; stop_o = 1'b1; din_o = req_q.addr[15:8]; end
      W_DEV:  begin start_o = 1'b1; write_o = 1'b1; din_o = {DEV_ADDR, 1'b0}; end
      W_REG:  begin write_o = 1'b1; din_o = req_q.addr[7:0]; end
      W_DATA: begin write_o = 1'b1; stop_o = 1'b1; din_o = req_q.wdata; end
      R_DEV:  begin start_o = 1'b1; write_o = 1'b1; din_o = {DEV_ADDR, 1'b1}; end
      R_DATA: begin read_o = 1'b1; stop_o = 1'b1; ack_in_o = 1'b1; end
      ABORT:  stop_o = 1'b1;
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = (state_q == RESP) & err_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: doc/si5340_reg_access.md
# si5340_reg_access

Register-access sequencer that turns single Si5340 register read/write requests into byte-level I2C commands. It drives the master side of the I2C byte-controller command interface (start/stop/read/write/ack_in/din; consumes cmd_ack/dout) and sits between the configuration loader's register-stream logic and the I2C byte controller. It handles Si5340 paging: it writes the page register (0x01) only when the target page differs from the cached page.

## Interface
- `DEV_ADDR`, default 7'h74: 7-bit I2C slave address.
- `PAGE_REG`, default 8'h01: page-select register offset.
- `DATA_WIDTH`, default 8: byte width; only 8 is supported.
- `clk_i`, input, 1: clock.
- `arstn_i`, input, 1: reset, asynchronous, active-low; the block has one clock.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: request accepted when valid & ready.
- `req_we_i`, input, 1: 1 = write, 0 = read.
- `req_addr_i`, input, 16: [15:8] page, [7:0] register offset.
- `req_wdata_i`, input, 8: write data.
- `rsp_valid_o`, output, 1: one-cycle pulse when a request completes.
- `rsp_rdata_o`, output, 8: read data, valid with `rsp_valid_o`.
- `rsp_err_o`, output, 1: slave NACK seen, valid with `rsp_valid_o`.
- `busy_o`, output, 1: transaction in progress.
- `start_o`, `stop_o`, `read_o`, `write_o`, `ack_in_o`, output, 1 each: byte-controller command bits.
- `din_o`, output, 8: byte to transmit.
- `dout_i`, input, 8: received byte.
- `cmd_ack_i`, input, 1: command-complete pulse.
- `rx_ack_i`, input, 1: slave acknowledge from the last written byte; 1 = NACK.

## Operation
- Reset values:
  - `req_ready_o` = 1; all other outputs = 0.
  - Page cache is invalid.
- A request is accepted only in IDLE. On accept, addr, we and wdata are latched and `req_ready_o` drops.
- Page phase: runs if the cache is invalid or the latched page differs from the cached page.
  - PG_DEV: start+write, din = {DEV_ADDR,0}.
  - PG_REG: write, din = PAGE_REG.
  - PG_VAL: write+stop, din = page.
  - On completion: cache := page, cache valid.
- Write phase:
  - W_DEV: start+write, din = {DEV_ADDR,0}.
  - W_REG: write, din = offset.
  - W_DATA: write+stop, din = wdata.
- Read phase:
  - W_DEV, then W_REG.
  - R_DEV: start+write, din = {DEV_ADDR,1}.
  - R_DATA: read+stop, ack_in = 1 (master NACK). `dout_i` is captured on `cmd_ack_i`.
- Each command state holds its command bits and din steady until `cmd_ack_i` is sampled high.
  - On that edge the next state's command is loaded, so commands run back-to-back with no idle cycle.
  - Only one command bit group is active per state.
- NACK handling: in a write-type state, `cmd_ack_i` with `rx_ack_i` = 1 moves the block to ABORT.
  - ABORT issues stop only, then goes to RESP with err = 1.
  - The page cache is invalidated.
  - `rx_ack_i` is ignored in R_DATA.
- RESP: `rsp_valid_o` pulses for one cycle, then the block returns to IDLE with `req_ready_o` = 1.
- `cmd_ack_i` in IDLE or RESP is ignored.
- `busy_o` = 1 in every state except IDLE.
- Reset mid-transaction: all command bits drop immediately (asynchronous), the cache is invalidated and no response is issued.

## Timing
- Accept edge, then the first command bits are asserted in the next cycle.
- Response latency is N command acks + 2 cycles, where N is:
  - write, same page: 3.
  - write, page change: 6.
  - read, same page: 4.
  - read, page change: 7.
- `rsp_valid_o` is asserted the cycle after the final `cmd_ack_i`.
- `rsp_rdata_o` holds its value until the next read completes. It is 0 after reset.
- `rsp_err_o` is meaningful only while `rsp_valid_o` = 1.

## Structure
- Package `si5340_pkg`:
  - state enum (IDLE, PG_DEV, PG_REG, PG_VAL, W_DEV, W_REG, W_DATA, R_DEV, R_DATA, ABORT, RESP).
  - constants DEF_DEV_ADDR = 7'h74 and PAGE_REG = 8'h01.
  - request struct {we, addr[15:0], wdata[7:0]}.
- Single module. The command outputs are grouped as the master modport of the existing I2C control interface at the top-level connection.

## Test plan
- Write 0x0B24 := 0xC0 after reset → 6 commands: [S+W 0xE8], [W 0x01], [W+P 0x0B], [S+W 0xE8], [W 0x24], [W+P 0xC0]; response err = 0.
- Second write 0x0B25 := 0x00 → 3 commands only (page cached); response follows the last `cmd_ack_i` by 1 cycle.
- Read 0x0B26 with model returning 0x5A → [S+W 0xE8], [W 0x26], [S+W 0xE9], [R+P, ack_in = 1]; rdata = 0x5A, err = 0.
- NACK on the device-address byte → stop-only command, then response err = 1. The next request to the same page redoes the page phase.
- `req_valid_i` held during a transaction → no second accept until the RESP→IDLE transition; a delayed `cmd_ack_i` (20 cycles) keeps command bits stable.
- `arstn_i` asserted mid-W_REG → outputs 0 at once; after release the next write performs the page phase.
